centering_unit: RTL and testbench

Mean-removal engine for the whitening stage. Sits behind the whitening controller's `GO_cen` / `En_mem1` sequencing: it accumulates a frame of two-channel samples from memory 1, computes the per-channel mean by shift, then streams the centred samples toward the covariance path. It reports `CEN_busy` back to the controller and flags completion.

---
 rtl/whitening_pkg.sv | 27 ++
 rtl/cen_channel.sv | 50 +++++
 rtl/centering_unit.sv | 142 ++++++++++++++
 tb/tb_centering_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/whitening_pkg.sv
// Shared definitions for the whitening stage: frame geometry, centering FSM
// states and the saturating subtract used on the centred output path.
package whitening_pkg;

  localparam int DATA_W    = 32;
  localparam int LOG2_N    = 7;
  localparam int N_SAMPLES = 1 << LOG2_N;

  typedef enum logic [2:0] {
    IDLE,
    SUM,
    DIV,
    SUB,
    DONE
  } cen_state_t;

  // a - b evaluated one bit wider, then clamped to the DATA_W signed range
  function automatic logic [DATA_W-1:0] sat_sub(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic signed [DATA_W:0] diff;
    diff = $signed({a[DATA_W-1], a}) - $signed({b[DATA_W-1], b});
    if (diff[DATA_W] != diff[DATA_W-1])
      return diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    return diff[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/cen_channel.sv
// One channel of the centering datapath: frame accumulator, floor mean and
// saturated mean removal, sequenced by strobes from the centering FSM.
module cen_channel
  import whitening_pkg::sat_sub;
#(
  parameter int DATA_W = 32,
  parameter int LOG2_N = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              acc_en_i,
  input  logic              div_en_i,
  input  logic              sub_en_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] mean_o,
  output logic [DATA_W-1:0] dout_o
);

  localparam int ACC_W = DATA_W + LOG2_N;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]       mean_q;
  logic [DATA_W-1:0]       dout_q;

  // A clear and an add in the same cycle starts a new frame with this sample
  always_comb begin
    acc_d = clr_i ? '0 : acc_q;
    if (acc_en_i)
      acc_d = acc_d + ACC_W'($signed(din_i));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      mean_q <= '0;
      dout_q <= '0;
    end else begin
      acc_q <= acc_d;
      if (div_en_i)
        mean_q <= DATA_W'(acc_q >>> LOG2_N);
      if (sub_en_i)
        dout_q <= sat_sub(din_i, mean_q);
    end
  end

  assign mean_o = mean_q;
  assign dout_o = dout_q;

endmodule

// File: rtl/centering_unit.sv
// Mean-removal engine: sums a two-channel frame, takes the floor mean by
// shift, then streams centred samples with busy/valid/done signalling.
module centering_unit #(
  parameter int DATA_W    = whitening_pkg::DATA_W,
  parameter int LOG2_N    = whitening_pkg::LOG2_N,
  parameter int N_SAMPLES = whitening_pkg::N_SAMPLES
) (
  input  logic              CLK_cen,
  input  logic              RST_cen,
  input  logic              GO_cen,
  input  logic              En_mem1,
  input  logic [DATA_W-1:0] Din_x1,
  input  logic [DATA_W-1:0] Din_x2,
  output logic              CEN_busy,
  output logic              Dout_valid,
  output logic [DATA_W-1:0] Dout_z1,
  output logic [DATA_W-1:0] Dout_z2,
  output logic [DATA_W-1:0] Mean_1,
  output logic [DATA_W-1:0] Mean_2,
  output logic              Cen_done
);

  import whitening_pkg::*;

  localparam logic [LOG2_N-1:0] CNT_LAST = LOG2_N'(N_SAMPLES - 1);

  cen_state_t        state_q, state_d;
  logic [LOG2_N-1:0] cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              accept, clr, acc_en, div_en, sub_en;

  always_comb begin
    accept  = GO_cen & En_mem1;
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    clr     = 1'b0;
    acc_en  = 1'b0;
    div_en  = 1'b0;
    sub_en  = 1'b0;
    if (!GO_cen) begin
      // Abort: drop the frame but keep the last means
      state_d = IDLE;
      cnt_d   = '0;
      clr     = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          clr   = 1'b1;
          cnt_d = '0;
          if (accept) begin
            acc_en  = 1'b1;
            cnt_d   = LOG2_N'(1);
            state_d = SUM;
          end
        end
        SUM: begin
          if (accept) begin
            acc_en = 1'b1;
            if (cnt_q == CNT_LAST) begin
              cnt_d   = '0;
              state_d = DIV;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        DIV: begin
          div_en  = 1'b1;
          state_d = SUB;
        end
        SUB: begin
          if (accept) begin
            sub_en  = 1'b1;
            valid_d = 1'b1;
            if (cnt_q == CNT_LAST) begin
              cnt_d   = '0;
              state_d = DONE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        DONE: begin
          // valid_q is high only in the first DONE cycle (the last output)
          done_d = valid_q;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == SUM) || (state_d == DIV) || (state_d == SUB) ||
             ((state_d == DONE) && valid_d);
  end

  always_ff @(posedge CLK_cen or posedge RST_cen) begin
    if (RST_cen) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  cen_channel #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) u_ch1 (
    .clk_i    (CLK_cen),
    .rst_i    (RST_cen),
    .clr_i    (clr),
    .acc_en_i (acc_en),
    .div_en_i (div_en),
    .sub_en_i (sub_en),
    .din_i    (Din_x1),
    .mean_o   (Mean_1),
    .dout_o   (Dout_z1)
  );

  cen_channel #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) u_ch2 (
    .clk_i    (CLK_cen),
    .rst_i    (RST_cen),
    .clr_i    (clr),
    .acc_en_i (acc_en),
    .div_en_i (div_en),
    .sub_en_i (sub_en),
    .din_i    (Din_x2),
    .mean_o   (Mean_2),
    .dout_o   (Dout_z2)
  );

  assign CEN_busy   = busy_q;
  assign Dout_valid = valid_q;
  assign Cen_done   = done_q;

endmodule

// File: tb/tb_centering_unit.sv
// Scenario bench for centering_unit: per-scenario tasks drive frames, a
// scoreboard queue holds expected centred pairs popped as outputs appear.
module tb_centering_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic        en;
  logic [31:0] x1, x2;
  logic        busy, dv, done;
  logic [31:0] z1, z2, m1_o, m2_o;

  int nerr = 0;
  int nchk = 0;

  logic [63:0] sbq[$];
  int          a1[128], a2[128], b1[128], b2[128];
  logic [31:0] last_m1, last_m2;

  centering_unit dut (
    .CLK_cen    (clk),
    .RST_cen    (rst),
    .GO_cen     (go),
    .En_mem1    (en),
    .Din_x1     (x1),
    .Din_x2     (x2),
    .CEN_busy   (busy),
    .Dout_valid (dv),
    .Dout_z1    (z1),
    .Dout_z2    (z2),
    .Mean_1     (m1_o),
    .Mean_2     (m2_o),
    .Cen_done   (done)
  );

  always #5 clk = ~clk;

  // Scoreboard: every valid output pair is matched against the oldest expectation
  always @(negedge clk) begin : mon
    logic [63:0] e;
    if (!rst && dv) begin
      nchk++;
      if (sbq.size() == 0) begin
        nerr++;
        $display("FAIL dout_unexpected z1=%h z2=%h, no output expected", z1, z2);
      end else begin
        e = sbq.pop_front();
        if ({z1, z2} !== e) begin
          nerr++;
          $display("FAIL dout z1=%h z2=%h, expected z1=%h z2=%h", z1, z2, e[63:32], e[31:0]);
        end
      end
    end
  end

  function automatic logic [31:0] floor_mean(input int arr[128]);
    longint s;
    s = 0;
    for (int i = 0; i < 128; i++) s += longint'(arr[i]);
    return 32'(s >>> 7);
  endfunction

  function automatic logic [31:0] model_z(input logic [31:0] x, input logic [31:0] m);
    longint d;
    d = longint'($signed(x)) - longint'($signed(m));
    if (d > 64'sd2147483647) d = 64'sd2147483647;
    else if (d < -64'sd2147483648) d = -64'sd2147483648;
    return 32'(d);
  endfunction

  task automatic run_frame(input bit gaps, input bit div_hi, input string name);
    logic [31:0] em1, em2;
    em1 = floor_mean(a1);
    em2 = floor_mean(a2);
    go = 1'b1;
    for (int i = 0; i < 128; i++) begin
      en = 1'b1; x1 = a1[i]; x2 = a2[i];
      @(posedge clk); #1;
      nchk++;
      if (busy !== 1'b1) begin
        nerr++; $display("FAIL %s busy_sum[%0d] got %b, expected 1", name, i, busy);
      end
      if (gaps && i < 127) begin
        en = 1'b0; x1 = $urandom; x2 = $urandom;
        @(posedge clk); #1;
      end
    end
    // DIV cycle: any sample offered here must be ignored
    en = div_hi; x1 = 32'h7000_0000; x2 = 32'h9000_0000;
    @(posedge clk); #1;
    nchk++;
    if (m1_o !== em1) begin
      nerr++; $display("FAIL %s mean1 got %h, expected %h", name, m1_o, em1);
    end
    nchk++;
    if (m2_o !== em2) begin
      nerr++; $display("FAIL %s mean2 got %h, expected %h", name, m2_o, em2);
    end
    nchk++;
    if (dv !== 1'b0) begin
      nerr++; $display("FAIL %s valid_in_div got %b, expected 0", name, dv);
    end
    for (int i = 0; i < 128; i++) begin
      en = 1'b1; x1 = b1[i]; x2 = b2[i];
      sbq.push_back({model_z(b1[i], em1), model_z(b2[i], em2)});
      @(posedge clk); #1;
      nchk++;
      if (dv !== 1'b1 || done !== 1'b0) begin
        nerr++; $display("FAIL %s sub_latency[%0d] valid=%b done=%b, expected valid=1 done=0", name, i, dv, done);
      end
      if (gaps && i < 127) begin
        en = 1'b0; x1 = $urandom; x2 = $urandom;
        @(posedge clk); #1;
        nchk++;
        if (dv !== 1'b0) begin
          nerr++; $display("FAIL %s valid_gap[%0d] got %b, expected 0", name, i, dv);
        end
      end
    end
    en = 1'b0;
    nchk++;
    if (busy !== 1'b1) begin
      nerr++; $display("FAIL %s busy_last_out got %b, expected 1", name, busy);
    end
    @(posedge clk); #1;
    nchk++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      nerr++; $display("FAIL %s done_pulse done=%b busy=%b, expected done=1 busy=0", name, done, busy);
    end
    @(posedge clk); #1;
    nchk++;
    if (done !== 1'b0) begin
      nerr++; $display("FAIL %s done_width got %b, expected 0", name, done);
    end
    go = 1'b0;
    @(posedge clk); #1;
    nchk++;
    if (sbq.size() != 0) begin
      nerr++; $display("FAIL %s outputs_missing got %0d pending, expected 0", name, sbq.size());
    end
    last_m1 = em1;
    last_m2 = em2;
  endtask

  task automatic test_reset();
    rst = 1'b1; go = 1'b0; en = 1'b0; x1 = '0; x2 = '0;
    @(posedge clk); #1;
    nchk++;
    if ({busy, dv, done} !== 3'b000) begin
      nerr++; $display("FAIL reset_ctrl busy/valid/done got %b, expected 000", {busy, dv, done});
    end
    nchk++;
    if ({z1, z2, m1_o, m2_o} !== 128'd0) begin
      nerr++; $display("FAIL reset_data z=%h/%h mean=%h/%h, expected all 0", z1, z2, m1_o, m2_o);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_constant();
    for (int i = 0; i < 128; i++) begin
      a1[i] = 5; a2[i] = -3; b1[i] = 5; b2[i] = -3;
    end
    run_frame(1'b0, 1'b0, "constant");
  endtask

  task automatic test_ramp();
    for (int i = 0; i < 128; i++) begin
      a1[i] = i; a2[i] = -3 * i; b1[i] = i; b2[i] = -3 * i;
    end
    run_frame(1'b0, 1'b0, "ramp");
  endtask

  task automatic test_floor();
    for (int i = 0; i < 128; i++) begin
      a1[i] = 0; a2[i] = 0;
    end
    a1[77] = -1; a2[5] = -1;
    for (int i = 0; i < 128; i++) begin
      b1[i] = a1[i]; b2[i] = a2[i];
    end
    run_frame(1'b0, 1'b0, "floor");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 128; i++) begin
      a1[i] = (i < 64) ? 32'h7FFF_FFFF : 32'h8000_0000;
      a2[i] = -2;
      b1[i] = (i % 2 == 0) ? 32'h7FFF_FFFF : $urandom;
      b2[i] = (i % 3 == 0) ? 32'h7FFF_FFFF : ((i % 3 == 1) ? 32'h8000_0000 : $urandom);
    end
    run_frame(1'b0, 1'b0, "saturation");
  endtask

  task automatic test_gaps_div_drop();
    for (int i = 0; i < 128; i++) begin
      a1[i] = $urandom; a2[i] = $urandom_range(0, 2000) - 1000;
      b1[i] = $urandom; b2[i] = $urandom_range(0, 2000) - 1000;
    end
    run_frame(1'b1, 1'b1, "gaps_div");
  endtask

  task automatic test_abort();
    go = 1'b1;
    for (int i = 0; i < 60; i++) begin
      en = 1'b1; x1 = 32'd100000; x2 = 32'hFFF0_0000;
      @(posedge clk); #1;
    end
    // Abort with a sample still offered: the sample must be lost
    go = 1'b0;
    @(posedge clk); #1;
    nchk++;
    if ({busy, dv, done} !== 3'b000) begin
      nerr++; $display("FAIL abort_ctrl busy/valid/done got %b, expected 000", {busy, dv, done});
    end
    nchk++;
    if (m1_o !== last_m1 || m2_o !== last_m2) begin
      nerr++; $display("FAIL abort_means_kept got %h/%h, expected %h/%h", m1_o, m2_o, last_m1, last_m2);
    end
    en = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 128; i++) begin
      a1[i] = $urandom_range(0, 500); a2[i] = -i;
      b1[i] = $urandom_range(0, 500); b2[i] = i;
    end
    run_frame(1'b0, 1'b1, "after_abort");
  endtask

  task automatic test_reset_mid_sub();
    logic [31:0] em;
    for (int i = 0; i < 128; i++) a1[i] = 9;
    em = floor_mean(a1);
    go = 1'b1;
    for (int i = 0; i < 128; i++) begin
      en = 1'b1; x1 = 32'd9; x2 = 32'd9;
      @(posedge clk); #1;
    end
    en = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      en = 1'b1; x1 = i; x2 = 32'd20;
      sbq.push_back({model_z(i, em), model_z(32'd20, em)});
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    nchk++;
    if ({busy, dv, done} !== 3'b000) begin
      nerr++; $display("FAIL rst_mid_ctrl busy/valid/done got %b, expected 000", {busy, dv, done});
    end
    nchk++;
    if ({z1, z2, m1_o, m2_o} !== 128'd0) begin
      nerr++; $display("FAIL rst_mid_data z=%h/%h mean=%h/%h, expected all 0", z1, z2, m1_o, m2_o);
    end
    sbq.delete();
    go = 1'b0; en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    last_m1 = '0; last_m2 = '0;
  endtask

  initial begin
    last_m1 = '0; last_m2 = '0;
    test_reset();
    test_constant();
    test_ramp();
    test_floor();
    test_saturation();
    test_gaps_div_drop();
    test_abort();
    test_reset_mid_sub();
    test_constant();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
